// File: rtl/gcd_binary_engine.sv
// Stein's binary GCD engine: one shift/subtract step per clock, IDLE/STRIP/REDUCE/DONE.
// Optional iteration counter and `cycles` port are enabled by defining GCD_CYCLE_COUNT_EN.
module gcd_binary_engine #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] r
`ifdef GCD_CYCLE_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0] cycles
`endif
);

    localparam int K_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STRIP  = 2'd1,
        REDUCE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] a, a_n;
    logic [WIDTH-1:0] b, b_n;
    logic [K_W-1:0]   k, k_n;
    logic [WIDTH-1:0] r_n;
    logic             zero_op;

    assign zero_op = (a_in == '0) || (b_in == '0);
    assign ready   = (state == IDLE);
    assign done    = (state == DONE);

    always_comb begin
        state_n = state;
        a_n     = a;
        b_n     = b;
        k_n     = k;
        r_n     = r;
        case (state)
            IDLE: begin
                if (start) begin
                    a_n = a_in;
                    b_n = b_in;
                    k_n = '0;
                    if (zero_op) begin
                        r_n     = a_in | b_in;
                        state_n = DONE;
                    end else begin
                        state_n = STRIP;
                    end
                end
            end
            STRIP: begin
                // Pull out the common power of two; k remembers how many.
                if (!a[0] && !b[0]) begin
                    a_n = a >> 1;
                    b_n = b >> 1;
                    k_n = k + 1'b1;
                end else begin
                    state_n = REDUCE;
                end
            end
            REDUCE: begin
                if (!a[0]) begin
                    a_n = a >> 1;
                end else if (!b[0]) begin
                    b_n = b >> 1;
                end else if (a > b) begin
                    a_n = (a - b) >> 1;
                end else if (b > a) begin
                    b_n = (b - a) >> 1;
                end else begin
                    r_n     = a << k;
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            a     <= '0;
            b     <= '0;
            k     <= '0;
            r     <= '0;
        end else begin
            state <= state_n;
            a     <= a_n;
            b     <= b_n;
            k     <= k_n;
            r     <= r_n;
        end
    end

`ifdef GCD_CYCLE_COUNT_EN
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_inc;

    assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            cycles <= '0;
        end else begin
            if (state == IDLE && start) begin
                cnt <= '0;
            end else if (state == STRIP || state == REDUCE) begin
                cnt <= cnt_inc;
            end
            // The finishing REDUCE edge is itself counted; zero operands never iterate.
            if (state != DONE && state_n == DONE) begin
                cycles <= (state == IDLE) ? '0 : cnt_inc;
            end
        end
    end
`else
    // CNT_WIDTH only sizes the iteration counter, which this build leaves out.
    if (CNT_WIDTH < 1) begin : g_no_counter
    end
`endif

endmodule

// File: doc/gcd_binary_engine.md
GCD_BINARY_ENGINE -- requirements
Module: gcd_binary_engine

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter CNT_WIDTH, default 8, giving the cycle-counter width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: a request to begin a computation.
REQ-006 The block SHALL have ports a_in and b_in, input, WIDTH bits each: unsigned operands.
REQ-007 The block SHALL have port ready, output, 1 bit: the engine is idle and will accept start.
REQ-008 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking that r is valid.
REQ-009 The block SHALL have port r, output, WIDTH bits, registered: the GCD result.
REQ-010 The block SHALL have port cycles, output, CNT_WIDTH bits, registered: the iteration count of the last computation; this port SHALL exist only under GCD_CYCLE_COUNT_EN.

Function
REQ-011 The engine SHALL implement Stein's binary GCD with states IDLE, STRIP, REDUCE and DONE, performing one operation per clock.
REQ-012 In IDLE, ready SHALL be 1; start=1 SHALL latch a_in and b_in into registers a and b and clear k and the cycle counter.
REQ-013 On that same IDLE edge, if a_in==0 or b_in==0, the engine SHALL load r <= a_in|b_in and go to DONE; otherwise it SHALL go to STRIP.
REQ-014 In STRIP, if a[0]==0 and b[0]==0, the engine SHALL shift a and b right by 1, increment k and stay in STRIP; otherwise it SHALL go to REDUCE with no data change.
REQ-015 In REDUCE, priority order: if a is even, a >>= 1; else if b is even, b >>= 1; else if a>b, a <= (a-b)>>1; else if b>a, b <= (b-a)>>1; else (a==b) r <= a<<k and go to DONE.
REQ-016 k SHALL be ceil(log2(WIDTH))+1 bits wide; a<<k SHALL never overflow WIDTH bits, because the true GCD fits in WIDTH bits.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle, then the engine SHALL return to IDLE; ready SHALL be 0 in STRIP, REDUCE and DONE.
REQ-018 r and done SHALL become valid on the same edge; r SHALL hold its value until the next computation's DONE.
REQ-019 start asserted while ready==0 SHALL be ignored, and a_in and b_in SHALL not be sampled.
REQ-020 Latency SHALL be: zero operand, done 1 cycle after the accepting edge; otherwise 1 + (STRIP cycles) + (REDUCE cycles).
REQ-021 A start held high continuously SHALL begin a new computation on every IDLE cycle (back-to-back, one IDLE cycle between results).

Reset
REQ-022 When reset=1 at a clock edge, the engine SHALL go to IDLE, set r=0, done=0, ready=1, and clear a, b, k and cycles, regardless of current state.
REQ-023 Reset SHALL take priority over start in the same cycle; a computation in progress SHALL be abandoned with no done pulse.

Configuration
REQ-024 With GCD_CYCLE_COUNT_EN defined, the counter SHALL increment on every edge spent in STRIP or REDUCE, saturating at all-ones, and SHALL be copied to cycles on the DONE entry edge; a zero-operand computation SHALL report cycles=0.
REQ-025 Without GCD_CYCLE_COUNT_EN, the cycles port and the counter logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-026 Scenario (WIDTH=16): a_in=48, b_in=18, start pulse -> done 8 cycles after the accepting edge, r=6, cycles=7 (with the macro).
REQ-027 Scenario: a_in=0, b_in=35 -> done on the next cycle, r=35; a_in=0, b_in=0 -> r=0; cycles=0 in both cases.
REQ-028 Scenario: a_in=17, b_in=5 (coprime) -> r=1; a_in=b_in=32768 -> r=32768 with k=15 and no overflow.
REQ-029 Scenario: start 48/18, then start=1 with a_in=9, b_in=3 at cycle 3 -> the second start is ignored and r=6.
REQ-030 Scenario: start 48/18, then reset=1 at cycle 4 -> no done pulse, r=0 and ready=1 on the next cycle; a new start 21/14 -> r=7.
